// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a bounded hold time.
// Grants are break-before-make: every grant is followed by at least one idle cycle.
module rr_arbiter4 #(
  parameter int HOLD_MAX = 8,
  localparam int CNT_W = $clog2(HOLD_MAX)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       preempt
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

  state_t           state_reg;
  logic [1:0]       ptr_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic [3:0] req_rot;
  logic [1:0] win_off;
  logic [1:0] winner;

  // req_rot[k] is the request at position ptr+k, so bit 0 is the highest priority.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rot
      localparam logic [1:0] OFF = gi;
      logic [1:0] src;
      assign src         = ptr_reg + OFF;
      assign req_rot[gi] = req[src];
    end
  endgenerate

  always_comb begin
    win_off = 2'd3;
    if (req_rot[0])      win_off = 2'd0;
    else if (req_rot[1]) win_off = 2'd1;
    else if (req_rot[2]) win_off = 2'd2;
    winner = ptr_reg + win_off;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= 2'd0;
      cnt_reg   <= '0;
      gnt_idx   <= 2'd0;
      gnt_valid <= 1'b0;
      preempt   <= 1'b0;
    end else begin
      preempt <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (|req) begin
            gnt_idx   <= winner;
            gnt_valid <= 1'b1;
            cnt_reg   <= '0;
            state_reg <= GRANT;
          end
        end
        GRANT: begin
          // A release in the timeout cycle wins, so preempt stays low then.
          if (!req[gnt_idx]) begin
            gnt_valid <= 1'b0;
            ptr_reg   <= gnt_idx + 2'd1;
            state_reg <= IDLE;
          end else if (cnt_reg == CNT_LAST) begin
            gnt_valid <= 1'b0;
            preempt   <= 1'b1;
            ptr_reg   <= gnt_idx + 2'd1;
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Decoded from registered state only, so req has no path to gnt.
  assign gnt = gnt_valid ? (4'b0001 << gnt_idx) : 4'b0000;

endmodule

// File: doc/rr_arbiter4.md
Name: rr_arbiter4

Overview:
- Four-requester round-robin arbiter for one shared resource.
- Selects one requester, holds its grant, and drives the grant as a 2-bit index plus a one-hot vector using 2-to-4 decode semantics: index 0 gives 0001, index 3 gives 1000.
- Bounded hold time. A requester that exceeds it is preempted so it cannot starve the others.
- Sits between four client blocks and the resource's select and enable logic.

Parameters:
- HOLD_MAX, 8: maximum consecutive cycles one grant may be held. Legal range is 2..256.
- CNT_W, $clog2(HOLD_MAX): width of the hold counter. Derived; must not be overridden.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  4  request vector. req[i] high means requester i wants the resource or is still using it.
- gnt  output  4  one-hot grant. Equals decode(gnt_idx) when gnt_valid is 1, else 0000.
- gnt_idx  output  2  index of the granted requester. Holds its last value when gnt_valid is 0.
- gnt_valid  output  1  high while a grant is active.
- preempt  output  1  one-cycle pulse in the cycle a grant is removed by timeout.

Behaviour:
- Interface (already decided): one clock, clk. Reset rst is synchronous and active-high. Sampled only on the rising edge of clk.
- Reset values: state=IDLE, gnt=0000, gnt_idx=00, gnt_valid=0, preempt=0, ptr=00, cnt=0.
- Reset mid-grant drops gnt on the next edge. No completion of the current grant.
- All outputs are registered. gnt is combinationally derived from the registered gnt_idx and gnt_valid, so no glitch paths come from req.
- Internal state:
  - ptr (2 bits): highest-priority index for the next arbitration.
  - cnt (CNT_W bits): cycles the current grant has been held.
- State IDLE:
  - If req==0000: stay in IDLE.
  - Else: winner = first i with req[i]=1, searching ptr, ptr+1, ptr+2, ptr+3, all modulo 4.
  - Next edge: gnt_idx=winner, gnt_valid=1, cnt=0, state=GRANT.
  - Latency is one cycle: req sampled at edge N gives a grant visible after edge N.
- State GRANT, normal release (checked first):
  - If req[gnt_idx]=0, then next edge: gnt_valid=0, ptr=gnt_idx+1 (mod 4), state=IDLE.
- State GRANT, timeout:
  - Else if cnt==HOLD_MAX-1, then next edge: gnt_valid=0, preempt=1, ptr=gnt_idx+1, state=IDLE.
- State GRANT, otherwise: cnt=cnt+1 and stay in GRANT.
- Hold duration: gnt_valid is high for at most HOLD_MAX consecutive cycles.
- Gap rule: every grant is followed by at least one IDLE cycle with gnt=0000. There are no back-to-back grants without a gap, so handover is break-before-make.
- Same-cycle events: if req[gnt_idx] drops in the same cycle cnt reaches HOLD_MAX-1, treat it as a normal release and keep preempt=0.
- preempt is high for exactly one cycle: the first IDLE cycle after a timeout. It is 0 at all other times.
- Sole requester: if the preempted requester still requests and no one else does, it is re-granted after the one-cycle gap.
- Fairness: requests on non-granted lines during GRANT are ignored until the next IDLE. ptr rotation guarantees each continuously requesting client a grant within 3 grant periods.
- ptr wraps 3 to 0. cnt never exceeds HOLD_MAX-1.

Test Plan:
- Reset: assert rst for 2 cycles with req=1111 → gnt=0000, gnt_valid=0, gnt_idx=00, preempt=0. After release, the first grant is gnt=0001 (ptr=0).
- Single request: req=0100 from cycle 0, dropped after 3 granted cycles → gnt=0100 and gnt_idx=10 one cycle after req, for 3 cycles. Then gnt=0000, ptr=11, preempt=0.
- Round-robin: req=1111 held, HOLD_MAX=8 → grant sequence 0001, 1000? No: 0001, 0010, 0100, 1000, 0001. Each lasts 8 cycles with a 1-cycle gap and preempt pulsing once per gap.
- Priority pointer: grant 1 released (ptr=10), then req=0011 → next grant is 0001 (search 2,3,0), not 0010.
- Same-cycle tie: with HOLD_MAX=4, drop req[gnt_idx] in the 4th granted cycle → grant ends with preempt=0.
- Reset mid-grant: rst at cycle 3 of a grant → gnt=0000 after that edge and ptr=00. With req=1111 after release, gnt=0001.
